// File: rtl/aes_enc_arb.sv
// Round-robin arbiter/sequencer sharing one AES encryption core between NREQ requesters.
// Optional watchdog and early-result checking: define AES_ENC_ARB_WDOG_EN.
module aes_enc_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*128-1:0]  req_data,
    input  logic [NREQ*128-1:0]  req_key,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [127:0]         rsp_data,
    output logic [IDW-1:0]       rsp_id,
    output logic                 core_valid_o,
    output logic [127:0]         core_data_o,
    output logic [127:0]         core_key_o,
    input  logic [127:0]         core_res_i,
    input  logic                 core_valid_i,
    output logic                 err
);

    localparam int unsigned BW = 128;
    localparam int unsigned CW = 4;
    localparam logic [IDW-1:0] PTR_RST = IDW'(NREQ - 1);
`ifdef AES_ENC_ARB_WDOG_EN
    localparam logic [CW-1:0] CNT_EARLY = CW'(10);
    localparam logic [CW-1:0] CNT_MAX   = CW'(15);
`endif

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_t;

    state_t          state;
    logic [IDW-1:0]  last_ptr;
    logic [IDW-1:0]  id_q;
    logic [CW-1:0]   cnt;

    logic [IDW-1:0]  grant;
    logic            grant_vld;
    logic            accept;
    logic [BW-1:0]   sel_data;
    logic [BW-1:0]   sel_key;
    int unsigned     idx;

    // Round-robin search starting one past the last winner
    always_comb begin
        grant     = last_ptr;
        grant_vld = 1'b0;
        idx       = 0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            idx = (32'(last_ptr) + i) % NREQ;
            if (!grant_vld && req_valid[IDW'(idx)]) begin
                grant     = IDW'(idx);
                grant_vld = 1'b1;
            end
        end
    end

    // Payload mux for the granted requester
    always_comb begin
        sel_data = '0;
        sel_key  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == grant) begin
                sel_data = req_data[i*BW +: BW];
                sel_key  = req_key[i*BW +: BW];
            end
        end
    end

    // Accept only when idle and the response slot is free or draining this cycle
    always_comb begin
        req_ready = '0;
        if (resetn && (state == ST_IDLE) && grant_vld && (!rsp_valid || rsp_ready))
            req_ready[grant] = 1'b1;
    end

    assign accept = |(req_valid & req_ready);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= ST_IDLE;
            last_ptr     <= PTR_RST;
            id_q         <= '0;
            cnt          <= '0;
            rsp_valid    <= 1'b0;
            rsp_data     <= '0;
            rsp_id       <= '0;
            core_valid_o <= 1'b0;
            core_data_o  <= '0;
            core_key_o   <= '0;
`ifdef AES_ENC_ARB_WDOG_EN
            err          <= 1'b0;
`endif
        end else begin
            core_valid_o <= 1'b0;
            if (rsp_valid && rsp_ready)
                rsp_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        core_data_o  <= sel_data;
                        core_key_o   <= sel_key;
                        id_q         <= grant;
                        last_ptr     <= grant;
                        core_valid_o <= 1'b1;
                        state        <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    cnt <= cnt + CW'(1);
                    if (core_valid_i) begin
                        rsp_data  <= core_res_i;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= ST_IDLE;
`ifdef AES_ENC_ARB_WDOG_EN
                        if (cnt < CNT_EARLY)
                            err <= 1'b1;
`endif
                    end
`ifdef AES_ENC_ARB_WDOG_EN
                    else if (cnt == CNT_MAX) begin
                        // Core never answered: flag and drop the job
                        err   <= 1'b1;
                        state <= ST_IDLE;
                    end
`endif
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef AES_ENC_ARB_WDOG_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_aes_enc_arb.sv
// Directed bench for aes_enc_arb with an 11-cycle core stub.
`timescale 1ns/1ps
module tb_aes_enc_arb;
    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    typedef struct {
        int unsigned  id;
        logic [127:0] data;
        logic [127:0] key;
        logic [127:0] exp_res;
    } vec_t;

    logic                clk;
    logic                resetn;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*128-1:0] req_data;
    logic [NREQ*128-1:0] req_key;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [127:0]        rsp_data;
    logic [IDW-1:0]      rsp_id;
    logic                core_valid_o;
    logic [127:0]        core_data_o;
    logic [127:0]        core_key_o;
    logic [127:0]        core_res_i;
    logic                core_valid_i;
    logic                err;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    int multi_ready = 0;

    aes_enc_arb #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_key(req_key),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id),
        .core_valid_o(core_valid_o), .core_data_o(core_data_o), .core_key_o(core_key_o),
        .core_res_i(core_res_i), .core_valid_i(core_valid_i),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Core stub: result appears 11 cycles after the launch pulse
    function automatic logic [127:0] core_model(input logic [127:0] d, input logic [127:0] k);
        if (d == FIPS_PT && k == FIPS_KEY) return FIPS_CT;
        return d ^ k;
    endfunction

    int           stub_cnt  = 0;
    logic         stub_mute = 1'b0;
    logic         inject    = 1'b0;
    logic [127:0] stub_res  = '0;

    always @(posedge clk) begin
        if (core_valid_o) begin
            stub_cnt <= 1;
            stub_res <= core_model(core_data_o, core_key_o);
        end else if (stub_cnt == 11) stub_cnt <= 0;
        else if (stub_cnt != 0)      stub_cnt <= stub_cnt + 1;
    end
    assign core_valid_i = ((stub_cnt == 11) && !stub_mute) || inject;
    assign core_res_i   = stub_res;

    // Event log, sampled mid-cycle
    int           acc_id[$];
    int           acc_cyc[$];
    int           rsp_id_q[$];
    int           rsp_cyc[$];
    int           rise_cyc[$];
    int           cvo_cyc[$];
    logic [127:0] rsp_data_q[$];
    logic         rsp_valid_d = 1'b0;

    always @(negedge clk) begin
        for (int i = 0; i < NREQ; i++)
            if (req_valid[i] && req_ready[i]) begin
                acc_id.push_back(i);
                acc_cyc.push_back(cyc);
            end
        if ($countones(req_ready) > 1) multi_ready <= multi_ready + 1;
        if (rsp_valid && !rsp_valid_d) rise_cyc.push_back(cyc);
        if (rsp_valid && rsp_ready) begin
            rsp_id_q.push_back(int'(rsp_id));
            rsp_data_q.push_back(rsp_data);
            rsp_cyc.push_back(cyc);
        end
        if (core_valid_o) cvo_cyc.push_back(cyc);
        rsp_valid_d <= rsp_valid;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_acc(input int target, input int budget, input string name);
        int t = 0;
        while (acc_id.size() < target && t < budget) begin tick(1); t++; end
        check(name, 128'(acc_id.size() >= target), 128'(1));
    endtask

    task automatic wait_rsp(input int target, input int budget, input string name);
        int t = 0;
        while (rsp_cyc.size() < target && t < budget) begin tick(1); t++; end
        check(name, 128'(rsp_cyc.size() >= target), 128'(1));
    endtask

    task automatic hold_reset(input logic [NREQ-1:0] vld);
        resetn    = 1'b0;
        req_valid = vld;
        rsp_ready = 1'b1;
        stub_mute = 1'b0;
        inject    = 1'b0;
        tick(16);
    endtask

    task automatic check_reset_vals(input string nm);
        check({nm, "_req_ready"}, 128'(req_ready), 128'(0));
        check({nm, "_rsp_valid"}, 128'(rsp_valid), 128'(0));
        check({nm, "_core_valid"}, 128'(core_valid_o), 128'(0));
        check({nm, "_err"}, 128'(err), 128'(0));
        check({nm, "_rsp_data"}, rsp_data, 128'(0));
        check({nm, "_rsp_id"}, 128'(rsp_id), 128'(0));
        check({nm, "_core_data"}, core_data_o, 128'(0));
        check({nm, "_core_key"}, core_key_o, 128'(0));
    endtask

    task automatic run_job(input vec_t v, input string nm);
        int a0 = acc_id.size();
        int r0 = rsp_cyc.size();
        int c0 = cvo_cyc.size();
        req_data[v.id*128 +: 128] = v.data;
        req_key[v.id*128 +: 128]  = v.key;
        req_valid[v.id] = 1'b1;
        wait_acc(a0 + 1, 20, {nm, "_acc_timeout"});
        req_valid[v.id] = 1'b0;
        wait_rsp(r0 + 1, 30, {nm, "_rsp_timeout"});
        tick(2);
        if (acc_id.size() > a0 && rsp_cyc.size() > r0) begin
            check({nm, "_acc_id"}, 128'(acc_id[a0]), 128'(v.id));
            check({nm, "_rsp_id"}, 128'(rsp_id_q[r0]), 128'(v.id));
            check({nm, "_rsp_data"}, rsp_data_q[r0], v.exp_res);
            check({nm, "_latency"}, 128'(rsp_cyc[r0] - acc_cyc[a0]), 128'(13));
            check({nm, "_launch_cnt"}, 128'(cvo_cyc.size() - c0), 128'(1));
            if (cvo_cyc.size() > c0)
                check({nm, "_launch_cyc"}, 128'(cvo_cyc[c0] - acc_cyc[a0]), 128'(1));
        end
    endtask

    vec_t vecs[4];

    initial begin
        int a0, r0, rz0, c0, bad;
        logic [127:0] snap_d;
        logic [IDW-1:0] snap_id;

        vecs[0] = '{2, FIPS_PT, FIPS_KEY, FIPS_CT};
        vecs[1] = '{0, {16{8'h0f}}, {16{8'hff}}, {16{8'hf0}}};
        vecs[2] = '{3, 128'h0123456789abcdef_fedcba9876543210,
                       128'hffffffff_00000000_ffffffff_00000000,
                       128'hfedcba98_89abcdef_01234567_76543210};
        vecs[3] = '{1, 128'h80000000_00000000_00000000_00000001, 128'h0,
                       128'h80000000_00000000_00000000_00000001};

        req_data = '0;
        req_key  = '0;
        for (int i = 0; i < NREQ; i++) req_data[i*128 +: 128] = {4{32'(i + 1)}};

        // Reset state with every requester asking, then round-robin from release
        hold_reset('1);
        check_reset_vals("rst");
        resetn = 1'b1;
        wait_acc(5, 100, "rr_acc_timeout");
        req_valid = '0;
        wait_rsp(5, 40, "rr_rsp_timeout");
        if (acc_id.size() >= 5 && rsp_cyc.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                check($sformatf("rr_order%0d", k), 128'(acc_id[k]), 128'(k % 4));
                check($sformatf("rr_rsp_id%0d", k), 128'(rsp_id_q[k]), 128'(k % 4));
                check($sformatf("rr_rsp_data%0d", k), rsp_data_q[k], {4{32'(k % 4 + 1)}});
                if (k > 0)
                    check($sformatf("rr_spacing%0d", k), 128'(acc_cyc[k] - acc_cyc[k-1]), 128'(13));
            end
        end

        // Single jobs, FIPS-197 vector first
        hold_reset('0);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) run_job(vecs[i], $sformatf("vec%0d", i));

        // Backpressure: response held, next accept lands in the handshake cycle
        hold_reset('0);
        resetn = 1'b1;
        rsp_ready = 1'b0;
        a0 = acc_id.size(); r0 = rsp_cyc.size(); rz0 = rise_cyc.size();
        req_data[1*128 +: 128] = 128'hdeadbeef_00000001_cafef00d_00000011;
        req_data[2*128 +: 128] = 128'h12345678_9abcdef0_0fedcba9_87654321;
        req_key = '0;
        req_valid = 4'b0110;
        wait_acc(a0 + 1, 5, "bp_acc_timeout");
        req_valid[1] = 1'b0;
        begin
            int t = 0;
            while (rise_cyc.size() == rz0 && t < 30) begin tick(1); t++; end
        end
        check("bp_rise_timeout", 128'(rise_cyc.size() > rz0), 128'(1));
        snap_d = rsp_data;
        snap_id = rsp_id;
        bad = 0;
        repeat (20) begin
            if (rsp_data !== snap_d || rsp_id !== snap_id || req_ready !== '0 || rsp_valid !== 1'b1)
                bad++;
            tick(1);
        end
        check("bp_hold_stable", 128'(bad), 128'(0));
        check("bp_hold_id", 128'(snap_id), 128'(1));
        check("bp_hold_data", snap_d, 128'hdeadbeef_00000001_cafef00d_00000011);
        rsp_ready = 1'b1;
        tick(1);
        req_valid[2] = 1'b0;
        if (acc_id.size() > a0 + 1 && rsp_cyc.size() > r0) begin
            check("bp_next_id", 128'(acc_id[a0+1]), 128'(2));
            check("bp_next_cyc", 128'(acc_cyc[a0+1]), 128'(rsp_cyc[r0]));
        end else check("bp_next_acc", 128'(acc_id.size() - a0), 128'(2));
        wait_rsp(r0 + 2, 30, "bp_rsp2_timeout");
        if (rsp_cyc.size() >= r0 + 2) begin
            check("bp_rsp2_id", 128'(rsp_id_q[r0+1]), 128'(2));
            check("bp_rsp2_data", rsp_data_q[r0+1], 128'h12345678_9abcdef0_0fedcba9_87654321);
        end

        // Requester 0 withdraws; grant moves to requester 1
        hold_reset('0);
        resetn = 1'b1;
        a0 = acc_id.size(); r0 = rsp_cyc.size();
        req_valid = 4'b0011;
        wait_acc(a0 + 1, 5, "wd0_acc_timeout");
        req_valid[0] = 1'b0;
        wait_acc(a0 + 2, 20, "wd1_acc_timeout");
        req_valid[1] = 1'b0;
        req_valid[0] = 1'b1;
        tick(3);
        req_valid[0] = 1'b0;
        wait_rsp(r0 + 2, 30, "wd_rsp_timeout");
        tick(20);
        check("wd_acc_count", 128'(acc_id.size() - a0), 128'(2));
        check("wd_rsp_count", 128'(rsp_cyc.size() - r0), 128'(2));
        if (acc_id.size() >= a0 + 2 && rsp_cyc.size() >= r0 + 2) begin
            check("wd_acc_first", 128'(acc_id[a0]), 128'(0));
            check("wd_acc_second", 128'(acc_id[a0+1]), 128'(1));
            check("wd_rsp_first", 128'(rsp_id_q[r0]), 128'(0));
            check("wd_rsp_second", 128'(rsp_id_q[r0+1]), 128'(1));
        end

        // Reset in the middle of a job, then a stray core pulse
        hold_reset('0);
        resetn = 1'b1;
        a0 = acc_id.size(); rz0 = rise_cyc.size(); c0 = cvo_cyc.size();
        req_data[3*128 +: 128] = 128'h55555555_aaaaaaaa_33333333_cccccccc;
        req_valid[3] = 1'b1;
        wait_acc(a0 + 1, 5, "mr_acc_timeout");
        req_valid[3] = 1'b0;
        tick(5);
        resetn = 1'b0;
        tick(1);
        check_reset_vals("mr");
        resetn = 1'b1;
        inject = 1'b1;
        tick(1);
        inject = 1'b0;
        tick(20);
        check("mr_no_rsp", 128'(rise_cyc.size() - rz0), 128'(0));
        check("mr_rsp_valid", 128'(rsp_valid), 128'(0));
        check("mr_err", 128'(err), 128'(0));
        check("mr_launch_cnt", 128'(cvo_cyc.size() - c0), 128'(1));

`ifdef AES_ENC_ARB_WDOG_EN
        // Silent core: watchdog fires, job dropped, arbiter recovers
        hold_reset('0);
        resetn = 1'b1;
        stub_mute = 1'b1;
        a0 = acc_id.size(); r0 = rsp_cyc.size();
        req_data[0*128 +: 128] = 128'h1;
        req_valid[0] = 1'b1;
        wait_acc(a0 + 1, 5, "wdg_acc_timeout");
        req_valid[0] = 1'b0;
        tick(16);
        check("wdg_err_before", 128'(err), 128'(0));
        tick(1);
        check("wdg_err_set", 128'(err), 128'(1));
        stub_mute = 1'b0;
        req_data[1*128 +: 128] = 128'h77;
        req_key[1*128 +: 128]  = 128'h0;
        req_valid[1] = 1'b1;
        wait_acc(a0 + 2, 3, "wdg_next_acc_timeout");
        req_valid[1] = 1'b0;
        if (acc_id.size() >= a0 + 2)
            check("wdg_next_cyc", 128'(acc_cyc[a0+1] - acc_cyc[a0]), 128'(18));
        wait_rsp(r0 + 1, 30, "wdg_rsp_timeout");
        tick(5);
        check("wdg_rsp_count", 128'(rsp_cyc.size() - r0), 128'(1));
        if (rsp_cyc.size() > r0) begin
            check("wdg_rsp_id", 128'(rsp_id_q[r0]), 128'(1));
            check("wdg_rsp_data", rsp_data_q[r0], 128'h77);
        end
        check("wdg_err_sticky", 128'(err), 128'(1));
`endif

        check("one_hot_ready", 128'(multi_ready), 128'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, got %0d checks, required completion", n_total);
        $fatal(1);
    end

endmodule

// File: doc/aes_enc_arb.md
# aes_enc_arb

Round-robin arbiter and sequencer that shares one `aes_enc_top` encryption core between `NREQ` requesters. It sits between the requesters and the core:
- accepts one plaintext/key job at a time over valid/ready;
- launches the job into the core as a single-cycle `data_valid_in` pulse;
- tracks the core's fixed 11-cycle round sequence;
- returns the ciphertext tagged with the requester index on a valid/ready response port.

## Interface
- `NREQ`, default 4: number of requesters, minimum 2.
- `IDW`, default `$clog2(NREQ)`: width of the response ID.

Clock and reset:
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, asynchronous and active-low.

Request side:
- `req_valid`, in, NREQ: per-requester job valid.
- `req_ready`, out, NREQ: per-requester accept. At most one bit is high.
- `req_data`, in, NREQ*128: plaintext. Requester k uses bits [k*128 +: 128].
- `req_key`, in, NREQ*128: key. Requester k uses bits [k*128 +: 128].

Response side:
- `rsp_valid`, out, 1: ciphertext available.
- `rsp_ready`, in, 1: consumer accepts the response.
- `rsp_data`, out, 128: ciphertext.
- `rsp_id`, out, IDW: index of the requester that owns `rsp_data`.

Core side:
- `core_valid_o`, out, 1: drives core `data_valid_in`.
- `core_data_o`, out, 128: drives core `data_in`.
- `core_key_o`, out, 128: drives core `key_in`.
- `core_res_i`, in, 128: from core `res_enc_out`.
- `core_valid_i`, in, 1: from core `res_valid_out`.

Error:
- `err`, out, 1: sticky watchdog/protocol error (see Configuration).

## Operation
States: IDLE, LAUNCH, WAIT.

IDLE:
- Grant is computed combinationally, round-robin, starting at `last_ptr+1` modulo NREQ.
- `req_ready[g]` is high only for the granted g, and only when `!rsp_valid || rsp_ready`.
- On handshake (`req_valid[g] && req_ready[g]`):
  - latch `req_data[g]` and `req_key[g]` into `core_data_o`/`core_key_o`;
  - latch g into the ID register;
  - set `last_ptr <= g`;
  - go to LAUNCH.
- No request: stay in IDLE, `last_ptr` unchanged.

LAUNCH:
- `core_valid_o = 1` for exactly this one cycle.
- Clear the cycle counter `cnt <= 0`; go to WAIT.

WAIT:
- `cnt` (4 bits) increments each cycle.
- On `core_valid_i`:
  - `rsp_data <= core_res_i`, `rsp_id <= ID register`, `rsp_valid <= 1`;
  - go to IDLE.

Response handling:
- `rsp_valid` is held, together with `rsp_data` and `rsp_id`, until `rsp_valid && rsp_ready`; then it clears.
- A new accept in the same cycle as the response handshake is legal.
- `core_valid_i` outside WAIT is ignored.
- `core_data_o`/`core_key_o` hold their values outside LAUNCH.

Reset values:
- state IDLE, `last_ptr` = NREQ-1 (requester 0 has priority first), `cnt` = 0.
- `req_ready` = 0, `rsp_valid` = 0, `core_valid_o` = 0, `err` = 0.
- `rsp_data` = 0, `rsp_id` = 0, `core_data_o` = 0, `core_key_o` = 0.

## Timing
- Request accepted in cycle T:
  - `core_valid_o` is high in T+1;
  - `core_valid_i` is expected in T+12 (`cnt` = 10);
  - `rsp_valid` rises in T+13.
- The earliest next accept is T+13, which also requires `rsp_ready` in that cycle. Otherwise the next accept happens in the cycle of the response handshake.
- Peak throughput: one job per 13 cycles.
- `req_ready` depends combinationally on `req_valid`, `rsp_valid` and `rsp_ready`. There is no combinational path from core inputs to requester outputs.
- Reset mid-job:
  - everything returns to reset values and the job is dropped;
  - a late `core_valid_i` pulse from the core is ignored, because the arbiter is in IDLE.

## Configuration
Macro `AES_ENC_ARB_WDOG_EN`.

Defined:
- In WAIT, if `cnt` reaches 15 without `core_valid_i`:
  - set `err <= 1`;
  - drop the job (no response);
  - return to IDLE.
- `core_valid_i` in WAIT with `cnt` < 10:
  - set `err <= 1`;
  - the result is still captured and returned normally.
- `err` clears only on reset.

Not defined:
- WAIT waits indefinitely for `core_valid_i`.
- `err` is tied to 0.
- The 4-bit counter may wrap.

## Test plan
1. **Single job, FIPS-197 vector.**
   - Stimulus: requester 2 sends key 000102030405060708090a0b0c0d0e0f and plaintext 00112233445566778899aabbccddeeff; `rsp_ready` held at 1.
   - Required: `rsp_valid` at T+13 with `rsp_data` = 69c4e0d86a7b0430d8cdb78070b4c55a and `rsp_id` = 2; `core_valid_o` high only in T+1.
2. **Round-robin order.**
   - Stimulus: all four `req_valid` held high from reset.
   - Required: accept order 0,1,2,3,0; accepts spaced 13 cycles apart; each `rsp_id` matches its accept.
3. **Backpressure.**
   - Stimulus: `rsp_ready` = 0 for 20 cycles after `rsp_valid` rises.
   - Required: `rsp_data`/`rsp_id` stable throughout; `req_ready` all zero; the next accept occurs in the handshake cycle.
4. **Requester withdraws while not granted.**
   - Stimulus: requester 1 is pending; requester 0 is granted and then drops `req_valid` before being re-granted.
   - Required: the grant moves to 1 with no lost or duplicated jobs.
5. **Reset mid-job.**
   - Stimulus: assert `resetn` = 0 at T+6, release, then inject a `core_valid_i` pulse.
   - Required: all outputs at reset values; no `rsp_valid`; `err` = 0.
6. **Watchdog** (`AES_ENC_ARB_WDOG_EN` defined).
   - Stimulus: core stub never asserts `core_valid_i`.
   - Required: `err` = 1 after WAIT `cnt` = 15; arbiter returns to IDLE; no response; the next job is accepted.
